// File: rtl/circle_span_pkg.sv
// Shared types and constants for the filled-circle span sequencer.
package circle_span_pkg;

    localparam int unsigned ROWS     = 61;
    localparam int unsigned CENTER_K = 30;
    localparam int unsigned COORD_W  = 9;
    localparam int unsigned SCOORD_W = 10;
    localparam int unsigned LEN_W    = 7;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned K_W      = 6;

    typedef enum logic [2:0] {IDLE, ADDR, CALC, EMIT, NEXT} state_t;

    typedef struct packed {
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] x;
        logic [LEN_W-1:0]   len;
    } span_t;

    // Rows mirror about the centre row, so the quarter LUT is walked up then down.
    function automatic logic [ADDR_W-1:0] row_addr(input logic [K_W-1:0] k);
        if (k <= K_W'(CENTER_K)) begin
            return ADDR_W'(k);
        end
        return ADDR_W'(K_W'(2 * CENTER_K) - k);
    endfunction

endpackage

// File: rtl/circle_span_clip.sv
// Converts centre x, row y and half-width into one span; screen clipping is
// built in only when CIRCLE_SPAN_CLIP_EN is defined.
module circle_span_clip
    import circle_span_pkg::*;
#(
    parameter int unsigned H_RES = 320,
    parameter int unsigned V_RES = 240
) (
    input  logic [COORD_W-1:0]         cx,
    input  logic signed [SCOORD_W-1:0] y,
    input  logic [ADDR_W-1:0]          w,
    output logic                       keep,
    output logic [COORD_W-1:0]         x,
    output logic [LEN_W-1:0]           len
);

    logic signed [SCOORD_W-1:0] x0;
    logic signed [SCOORD_W-1:0] x1;

    assign x0 = SCOORD_W'(cx) - SCOORD_W'(w);
    assign x1 = SCOORD_W'(cx) + SCOORD_W'(w);

`ifdef CIRCLE_SPAN_CLIP_EN
    localparam logic signed [SCOORD_W-1:0] H_LIM = SCOORD_W'(H_RES);
    localparam logic signed [SCOORD_W-1:0] V_LIM = SCOORD_W'(V_RES);

    logic signed [SCOORD_W-1:0] xs;
    logic signed [SCOORD_W-1:0] xe;

    // Clamp both ends to the visible line; empty or off-screen rows are dropped.
    assign xs   = x0[SCOORD_W-1] ? '0 : x0;
    assign xe   = (x1 >= H_LIM) ? (H_LIM - SCOORD_W'(1)) : x1;
    assign keep = !y[SCOORD_W-1] && (y < V_LIM) && !x1[SCOORD_W-1] && (x0 < H_LIM);
    assign x    = COORD_W'(xs);
    assign len  = LEN_W'(xe - xs + SCOORD_W'(1));
`else
    logic unused_clip;

    // Without clipping every row is kept and coordinates wrap modulo 512.
    assign keep        = 1'b1;
    assign x           = COORD_W'(x0);
    assign len         = LEN_W'({w, 1'b1});
    assign unused_clip = ^{y, x1, SCOORD_W'(H_RES), SCOORD_W'(V_RES)};
`endif

endmodule

// File: rtl/circle_span_seq.sv
// Walks the 61 rows of a filled circle through an external half-width LUT and
// emits one span per row on a valid/ready port. Clipping: CIRCLE_SPAN_CLIP_EN.
module circle_span_seq
    import circle_span_pkg::*;
#(
    parameter int unsigned H_RES = 320,
    parameter int unsigned V_RES = 240
) (
    input  logic                fclk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [COORD_W-1:0]  cx,
    input  logic [COORD_W-1:0]  cy,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   lut_addr,
    input  logic [ADDR_W-1:0]   lut_data,
    output logic                span_valid,
    input  logic                span_ready,
    output logic [COORD_W-1:0]  span_y,
    output logic [COORD_W-1:0]  span_x,
    output logic [LEN_W-1:0]    span_len
);

    localparam logic [K_W-1:0] K_LAST = K_W'(ROWS - 1);

    state_t                      state;
    logic [K_W-1:0]              k;
    logic [COORD_W-1:0]          cx_q;
    logic [COORD_W-1:0]          cy_q;
    span_t                       span_q;
    logic signed [SCOORD_W-1:0]  y_c;
    logic                        keep_c;
    logic [COORD_W-1:0]          clip_x_c;
    logic [LEN_W-1:0]            clip_len_c;

    // Row line relative to the latched centre; k=30 is the centre row.
    assign y_c = SCOORD_W'(cy_q) - SCOORD_W'(CENTER_K) + SCOORD_W'(k);

    circle_span_clip #(
        .H_RES (H_RES),
        .V_RES (V_RES)
    ) u_clip (
        .cx   (cx_q),
        .y    (y_c),
        .w    (lut_data),
        .keep (keep_c),
        .x    (clip_x_c),
        .len  (clip_len_c)
    );

    // Row walker; abort overrides every transition outside IDLE.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            k          <= '0;
            cx_q       <= '0;
            cy_q       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            lut_addr   <= '0;
            span_valid <= 1'b0;
            span_q     <= '0;
        end else begin
            done <= 1'b0;
            if (abort && (state != IDLE)) begin
                state      <= IDLE;
                busy       <= 1'b0;
                span_valid <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            cx_q  <= cx;
                            cy_q  <= cy;
                            k     <= '0;
                            busy  <= 1'b1;
                            state <= ADDR;
                        end
                    end
                    ADDR: begin
                        lut_addr <= row_addr(k);
                        state    <= CALC;
                    end
                    CALC: begin
                        if (keep_c) begin
                            span_q.y   <= COORD_W'(y_c);
                            span_q.x   <= clip_x_c;
                            span_q.len <= clip_len_c;
                            span_valid <= 1'b1;
                            state      <= EMIT;
                        end else begin
                            state <= NEXT;
                        end
                    end
                    EMIT: begin
                        if (span_ready) begin
                            span_valid <= 1'b0;
                            state      <= NEXT;
                        end
                    end
                    NEXT: begin
                        if (k == K_LAST) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            k     <= k + K_W'(1);
                            state <= ADDR;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign span_y   = span_q.y;
    assign span_x   = span_q.x;
    assign span_len = span_q.len;

endmodule

// File: tb/tb_circle_span_seq.sv
// Self-checking bench for circle_span_seq: directed vectors, backpressure,
// abort, reset and randomised walks against a row-by-row reference model.
module tb_circle_span_seq;

    typedef struct {
        int y;
        int x;
        int len;
    } exp_t;

    typedef struct {
        int cx;
        int cy;
        int idx;
        int y;
        int x;
        int len;
        int n;
    } vec_t;

    logic       fclk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [8:0] cx;
    logic [8:0] cy;
    logic       busy;
    logic       done;
    logic [4:0] lut_addr;
    logic [4:0] lut_data;
    logic       span_valid;
    logic       span_ready;
    logic [8:0] span_y;
    logic [8:0] span_x;
    logic [6:0] span_len;

    logic [4:0] rom [32];
    exp_t       exp_q[$];
    exp_t       got_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 fclk = ~fclk;

    assign lut_data = rom[lut_addr];

    circle_span_seq dut (
        .fclk       (fclk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .cx         (cx),
        .cy         (cy),
        .busy       (busy),
        .done       (done),
        .lut_addr   (lut_addr),
        .lut_data   (lut_data),
        .span_valid (span_valid),
        .span_ready (span_ready),
        .span_y     (span_y),
        .span_x     (span_x),
        .span_len   (span_len)
    );

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic int pack(input int y, input int x, input int len);
        return (y << 16) | (x << 7) | len;
    endfunction

    // Circle of radius 29.5 rows: largest w with (2w)^2 + (2d)^2 <= 59^2.
    function automatic int half_width(input int d);
        int w = 0;
        while (4 * (w + 1) * (w + 1) + 4 * d * d <= 3481) w++;
        return w;
    endfunction

    task automatic build_model(input int mcx, input int mcy);
        exp_q.delete();
        for (int k = 0; k < 61; k++) begin
            int d, w, y, x0, x1;
            exp_t e;
            d  = (k < 30) ? 30 - k : k - 30;
            w  = half_width(d);
            y  = mcy - 30 + k;
            x0 = mcx - w;
            x1 = mcx + w;
`ifdef CIRCLE_SPAN_CLIP_EN
            if (y < 0 || y >= 240 || x1 < 0 || x0 >= 320) continue;
            if (x0 < 0) x0 = 0;
            if (x1 > 319) x1 = 319;
            e = '{y, x0, x1 - x0 + 1};
`else
            e = '{y & 511, x0 & 511, 2 * w + 1};
`endif
            exp_q.push_back(e);
        end
    endtask

    task automatic run_walk(input int wcx, input int wcy, input bit rnd_ready,
                            input bit repulse, input bit with_abort);
        int   dones = 0;
        int   cyc = 0;
        int   n_exp;
        bit   bad_addr = 0;
        bit   held = 0;
        int   held_v = 0;
        exp_t e;
        exp_t g;
        build_model(wcx, wcy);
        n_exp = exp_q.size();
        got_q.delete();
        @(negedge fclk);
        cx = 9'(wcx); cy = 9'(wcy); start = 1'b1; abort = with_abort; span_ready = 1'b1;
        @(negedge fclk);
        start = 1'b0; abort = 1'b0;
        check("busy_after_start", int'(busy), 1);
        while (busy && cyc < 4000) begin
            if (held)
                check("span_hold", pack(int'(span_valid), int'(span_x), int'(span_len)) ^ (int'(span_y) << 20), held_v);
            if (repulse && (cyc == 17 || cyc == 140)) begin
                start = 1'b1; cx = 9'(wcx + 123); cy = 9'(wcy + 61);
            end else begin
                start = 1'b0; cx = 9'($urandom); cy = 9'($urandom);
            end
            span_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (lut_addr == 5'd31) bad_addr = 1'b1;
            held = span_valid && !span_ready;
            held_v = pack(int'(span_valid), int'(span_x), int'(span_len)) ^ (int'(span_y) << 20);
            if (span_valid && span_ready) begin
                g = '{int'(span_y), int'(span_x), int'(span_len)};
                if (exp_q.size() == 0) begin
                    check("extra_span", pack(g.y, g.x, g.len), -1);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("span%0d", got_q.size()), pack(g.y, g.x, g.len), pack(e.y, e.x, e.len));
                end
                got_q.push_back(g);
            end
            @(negedge fclk);
            cyc++;
            if (done) dones++;
        end
        start = 1'b0;
        repeat (3) begin
            @(negedge fclk);
            if (done) dones++;
        end
        check("walk_finished", int'(busy), 0);
        check("done_pulses", dones, 1);
        check("span_count", got_q.size(), n_exp);
        check("lut_addr_31", int'(bad_addr), 0);
    endtask

    initial begin
        vec_t tbl[6];
        int   n;
        int   cyc;
        int   dones;

        for (int a = 0; a < 32; a++)
            rom[a] = (a <= 30) ? 5'(half_width(30 - a)) : 5'h1f;

        tbl[0] = '{100, 100, 0, 70, 100, 1, 61};
        tbl[1] = '{100, 100, 1, 71, 95, 11, 61};
        tbl[2] = '{100, 100, 30, 100, 71, 59, 61};
        tbl[3] = '{100, 100, 60, 130, 100, 1, 61};
`ifdef CIRCLE_SPAN_CLIP_EN
        tbl[4] = '{10, 10, 0, 0, 0, 38, 41};
        tbl[5] = '{10, 10, 40, 40, 10, 1, 41};
`else
        tbl[4] = '{10, 10, 20, 0, 495, 55, 61};
        tbl[5] = '{10, 10, 0, 492, 10, 1, 61};
`endif

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; span_ready = 1'b1; cx = '0; cy = '0;
        repeat (3) @(negedge fclk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_valid", int'(span_valid), 0);
        check("rst_lut_addr", int'(lut_addr), 0);
        check("rst_span", pack(int'(span_y), int'(span_x), int'(span_len)), 0);
        rst_n = 1'b1;
        @(negedge fclk);

        foreach (tbl[i]) begin
            run_walk(tbl[i].cx, tbl[i].cy, 1'b0, 1'b0, 1'b0);
            check($sformatf("tbl%0d_count", i), got_q.size(), tbl[i].n);
            if (tbl[i].idx < got_q.size())
                check($sformatf("tbl%0d_span", i),
                      pack(got_q[tbl[i].idx].y, got_q[tbl[i].idx].x, got_q[tbl[i].idx].len),
                      pack(tbl[i].y, tbl[i].x, tbl[i].len));
            else
                check($sformatf("tbl%0d_missing", i), got_q.size(), tbl[i].idx + 1);
        end

        // Backpressure on the k=1 span.
        @(negedge fclk);
        cx = 9'd100; cy = 9'd100; start = 1'b1; span_ready = 1'b1;
        @(negedge fclk);
        start = 1'b0; n = 0; cyc = 0;
        while (cyc < 200 && !(span_valid && n == 1)) begin
            if (span_valid) n++;
            @(negedge fclk);
            cyc++;
        end
        check("bp_reached", n, 1);
        span_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            check("bp_valid", int'(span_valid), 1);
            check("bp_span", pack(int'(span_y), int'(span_x), int'(span_len)), pack(71, 95, 11));
            check("bp_lut_addr", int'(lut_addr), 1);
            @(negedge fclk);
        end
        span_ready = 1'b1;
        cyc = 0; dones = 0;
        while (busy && cyc < 1000) begin
            @(negedge fclk);
            cyc++;
            if (done) dones++;
        end
        check("bp_done", dones, 1);

        // Abort while the k=10 span is waiting in EMIT.
        @(negedge fclk);
        cx = 9'd100; cy = 9'd100; start = 1'b1; span_ready = 1'b1;
        @(negedge fclk);
        start = 1'b0; n = 0; cyc = 0;
        while (cyc < 500 && !(span_valid && n == 10)) begin
            if (span_valid) n++;
            @(negedge fclk);
            cyc++;
        end
        check("abort_reached", n, 10);
        span_ready = 1'b0; abort = 1'b1;
        @(negedge fclk);
        abort = 1'b0; span_ready = 1'b1;
        check("abort_busy", int'(busy), 0);
        check("abort_valid", int'(span_valid), 0);
        dones = int'(done);
        repeat (5) begin
            @(negedge fclk);
            if (done) dones++;
        end
        check("abort_no_done", dones, 0);
        run_walk(37, 200, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of a walk.
        @(negedge fclk);
        cx = 9'd200; cy = 9'd120; start = 1'b1;
        @(negedge fclk);
        start = 1'b0;
        repeat (20) @(negedge fclk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_valid", int'(span_valid), 0);
        check("midrst_lut_addr", int'(lut_addr), 0);
        check("midrst_done", int'(done), 0);
        @(negedge fclk);
        rst_n = 1'b1;
        repeat (3) @(negedge fclk);
        check("midrst_idle", int'(busy), 0);

        // Start together with abort in IDLE, and start pulses while busy.
        run_walk(250, 30, 1'b0, 1'b0, 1'b1);
        run_walk(100, 100, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 12; i++)
            run_walk(int'($urandom_range(0, 480)), int'($urandom_range(0, 480)), 1'b1,
                     (i % 4) == 1, (i % 5) == 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
